output_sram_scheduler: RTL and testbench
========================================

// Module: output_sram_scheduler
// PURPOSE
//  Sequences the PatchEmbed output SRAM (CHANNELS x SIZE*SIZE words of BIT_WIDTH) for one layer.
//  It arbitrates element writes from N_REQ producer lanes, one write per cycle, with round-robin priority.
//  It tracks per-channel completion and then streams every channel plane, 0..CHANNELS-1, to the consumer with valid/ready.
//  It sits between the conv/PE lanes and the output SRAM, and drives all SRAM control ports.
// PARAMETERS
//  BIT_WIDTH  30  width of one output element
//  CHANNELS   64  number of output channels (SRAM rows)
//  SIZE       27  plane edge; a plane holds SIZE*SIZE elements
//  N_REQ      4   number of producer lanes
// PORTS
//  clk           in   1                clock
//  reset         in   1                synchronous, active-high; shared with the SRAM
//  start         in   1                pulse; begins a layer (accepted only in IDLE)
//  req_valid     in   N_REQ            lane i has an element
//  req_ch        in   N_REQ*CH_W       lane i channel; must stay constant for a full plane
//  req_data      in   N_REQ*BIT_WIDTH  lane i element
//  req_ready     out  N_REQ            one-hot grant; a beat transfers on valid&ready
//  sram_w_en     out  1                registered SRAM write enable
//  sram_ch_addr  out  CH_W             registered write channel
//  sram_addr     out  ADDR_W           registered element index
//  sram_data_in  out  BIT_WIDTH        registered write data
//  sram_out_addr out  CH_W             registered read channel
//  rd_valid      out  1                SRAM data_out holds plane rd_ch
//  rd_ch         out  CH_W             channel currently presented
//  rd_ready      in   1                consumer accepts the plane
//  busy          out  1                state != IDLE
//  done          out  1                one-cycle pulse when the last plane is accepted
//  err           out  1                sticky protocol error; cleared by start or reset
// BEHAVIOUR
//  - Reset: state=IDLE and every output 0. Per-lane element counters, done bitmap and RR pointer are cleared.
//    Reset mid-layer aborts immediately with no completion pulse. The SRAM contents are cleared by the same reset.
//  - FSM states: IDLE, WRITE, RD_ISSUE, RD_HOLD.
//    IDLE -> WRITE on start. Entering WRITE clears the bitmap, the counters and err.
//    WRITE -> RD_ISSUE when the bitmap is all ones and sram_w_en==0 (write pipe drained).
//    RD_ISSUE (1 cycle): sram_out_addr=rd_ch, w_en=0. Next state is RD_HOLD.
//    RD_HOLD: rd_valid=1; data is stable because out_addr is held and w_en is low.
//    On rd_ready, if rd_ch==CHANNELS-1 then pulse done and go to IDLE. Otherwise increment rd_ch and go to RD_ISSUE.
//  - Arbitration: req_ready is nonzero only in WRITE.
//    Grant goes to the first valid lane at or after the RR pointer. The pointer moves to grant+1 (mod N_REQ) after each transfer.
//    Grant is combinational from req_valid and the pointer; no combinational path from any ready to any valid.
//  - Write pipe: a transfer on lane i registers w_en=1, ch_addr=req_ch[i], addr=cnt[i], data_in=req_data[i].
//    The SRAM commits on the following edge, so latency is 2 edges from handshake to stored.
//    With no transfer, w_en is 0 that cycle.
//  - Counters: cnt[i] (ADDR_W bits) increments per transfer on lane i.
//    At SIZE*SIZE-1 it wraps to 0 and sets done[req_ch[i]].
//  - Errors: err goes high and stays high if:
//    (a) a transfer targets a channel whose done bit is already set (the write is still performed);
//    (b) req_ch[i] >= CHANNELS (the write is dropped);
//    (c) req_ch[i] changes while cnt[i]!=0.
//  - start while busy is ignored. rd_ready outside RD_HOLD is ignored. Requests outside WRITE get no grant.
//  - Widths: CH_W=$clog2(CHANNELS), ADDR_W=$clog2(SIZE*SIZE). Compares are done at full counter width, with no truncation.
// STRUCTURE
//  - Package pe_out_pkg holds the CH_W/ADDR_W localparam functions and the state enum typedef (IDLE, WRITE, RD_ISSUE, RD_HOLD).
//  - Sub-module rr_arbiter #(N): req, ptr -> one-hot grant and grant index. Everything else stays in this module.
// TESTING (N_REQ=2, CHANNELS=4, SIZE=3 unless noted; SRAM model attached)
//  1. Reset in WRITE after 5 beats -> all outputs 0 next cycle, busy=0, SRAM all zero, and no done pulse.
//  2. Lane0 streams ch0 (9 beats of data 1..9) -> SRAM ch0 addr0..8 = 1..9; done[0] set on the 9th transfer.
//  3. Both lanes hold valid every cycle -> grants alternate 0,1,0,1; no lane starves; exactly one w_en per cycle.
//  4. All 4 planes written, rd_ready held low 5 cycles -> rd_valid=1, rd_ch=0 held stable, data_out constant.
//     Then ready pulses -> rd_ch goes 0,1,2,3; done pulses once.
//  5. Lane1 re-sends ch2 after ch2 is complete -> err=1 sticky; a new start clears it.
//  6. start pulsed during RD_HOLD -> ignored; readout completes unchanged.

Source files
------------

// File: rtl/output_sram_scheduler_pkg.sv
// Shared widths, state encoding and small helpers for the PatchEmbed output SRAM scheduler.
package pe_out_pkg;

    typedef enum logic [1:0] {IDLE, WRITE, RD_ISSUE, RD_HOLD} state_t;

    function automatic int ch_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    function automatic int addr_w(input int size);
        return (size * size > 1) ? $clog2(size * size) : 1;
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic ch_in_range(input int unsigned ch, input int unsigned channels);
        return ch < channels;
    endfunction

endpackage

// File: rtl/output_sram_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requesting lane at or after ptr.
module rr_arbiter
    import pe_out_pkg::*;
#(
    parameter int N = 4,
    localparam int IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    int idx;

    // Scan from farthest to nearest so the lane closest to ptr wins last.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        idx       = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/output_sram_scheduler.sv
// Output SRAM scheduler: round-robin element writes from N_REQ lanes, then
// per-channel plane readout to the consumer with valid/ready.
module output_sram_scheduler
    import pe_out_pkg::*;
#(
    parameter int BIT_WIDTH = 30,
    parameter int CHANNELS  = 64,
    parameter int SIZE      = 27,
    parameter int N_REQ     = 4,
    localparam int CH_W   = ch_w(CHANNELS),
    localparam int ADDR_W = addr_w(SIZE),
    localparam int IDX_W  = idx_w(N_REQ)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*CH_W-1:0]      req_ch,
    input  logic [N_REQ*BIT_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       sram_w_en,
    output logic [CH_W-1:0]            sram_ch_addr,
    output logic [ADDR_W-1:0]          sram_addr,
    output logic [BIT_WIDTH-1:0]       sram_data_in,
    output logic [CH_W-1:0]            sram_out_addr,
    output logic                       rd_valid,
    output logic [CH_W-1:0]            rd_ch,
    input  logic                       rd_ready,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int PLANE = SIZE * SIZE;

    state_t               state, state_nx;
    logic [CHANNELS-1:0]  ch_done;
    logic [ADDR_W-1:0]    cnt     [N_REQ];
    logic [CH_W-1:0]      last_ch [N_REQ];
    logic [IDX_W-1:0]     rr_ptr;
    logic [N_REQ-1:0]     grant;
    logic [IDX_W-1:0]     grant_idx;
    logic                 grant_en;
    logic                 all_done;
    logic                 xfer;
    logic [CH_W-1:0]      sel_ch;
    logic [BIT_WIDTH-1:0] sel_data;
    logic [ADDR_W-1:0]    sel_cnt;
    logic                 sel_wrap;
    logic                 last_rd;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign all_done = &ch_done;
    assign xfer     = |req_ready;
    assign sel_ch   = req_ch[int'(grant_idx)*CH_W +: CH_W];
    assign sel_data = req_data[int'(grant_idx)*BIT_WIDTH +: BIT_WIDTH];
    assign sel_cnt  = cnt[grant_idx];
    assign sel_wrap = (32'(sel_cnt) == 32'(PLANE - 1));
    assign last_rd  = (32'(rd_ch) == 32'(CHANNELS - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (start) state_nx = WRITE;
            WRITE:    if (all_done && !sram_w_en) state_nx = RD_ISSUE;
            RD_ISSUE: state_nx = RD_HOLD;
            RD_HOLD:  if (rd_ready) state_nx = last_rd ? IDLE : RD_ISSUE;
            default:  state_nx = IDLE;
        endcase
    end

    // Grants stop once every plane is complete so the write pipe can drain
    // before readout begins.
    always_comb begin
        grant_en  = (state == WRITE) && !all_done;
        req_ready = grant_en ? grant : '0;
        rd_valid  = (state == RD_HOLD);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sram_w_en     <= 1'b0;
            sram_ch_addr  <= '0;
            sram_addr     <= '0;
            sram_data_in  <= '0;
            sram_out_addr <= '0;
            rd_ch         <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
            ch_done       <= '0;
            rr_ptr        <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                cnt[i]     <= '0;
                last_ch[i] <= '0;
            end
        end else begin
            sram_w_en <= 1'b0;
            done      <= 1'b0;

            if (state == IDLE && start) begin
                ch_done <= '0;
                err     <= 1'b0;
                for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
            end

            // Out-of-range channels are flagged and dropped; re-writes of a
            // completed plane are flagged but still performed.
            if (xfer) begin
                rr_ptr           <= (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
                last_ch[grant_idx] <= sel_ch;
                if (sel_cnt != '0 && sel_ch != last_ch[grant_idx]) err <= 1'b1;
                if (!ch_in_range(32'(sel_ch), CHANNELS)) begin
                    err <= 1'b1;
                end else begin
                    sram_w_en    <= 1'b1;
                    sram_ch_addr <= sel_ch;
                    sram_addr    <= sel_cnt;
                    sram_data_in <= sel_data;
                    if (ch_done[sel_ch]) err <= 1'b1;
                    if (sel_wrap) begin
                        cnt[grant_idx]  <= '0;
                        ch_done[sel_ch] <= 1'b1;
                    end else begin
                        cnt[grant_idx] <= sel_cnt + 1'b1;
                    end
                end
            end

            // sram_out_addr leads into RD_ISSUE so the SRAM read lands by RD_HOLD.
            if (state == WRITE && state_nx == RD_ISSUE) begin
                rd_ch         <= '0;
                sram_out_addr <= '0;
            end
            if (state == RD_HOLD && rd_ready) begin
                if (last_rd) begin
                    done <= 1'b1;
                end else begin
                    rd_ch         <= rd_ch + 1'b1;
                    sram_out_addr <= rd_ch + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_output_sram_scheduler.sv
// Scoreboard bench for output_sram_scheduler with an attached SRAM model.
module tb_output_sram_scheduler;
    import pe_out_pkg::*;

    localparam int BIT_WIDTH = 30;
    localparam int CHANNELS  = 4;
    localparam int SIZE      = 3;
    localparam int N_REQ     = 2;
    localparam int CH_W      = ch_w(CHANNELS);
    localparam int ADDR_W    = addr_w(SIZE);
    localparam int PLANE     = SIZE * SIZE;

    logic                       clk = 1'b0;
    logic                       reset = 1'b1;
    logic                       start = 1'b0;
    logic [N_REQ-1:0]           req_valid = '0;
    logic [N_REQ*CH_W-1:0]      req_ch = '0;
    logic [N_REQ*BIT_WIDTH-1:0] req_data = '0;
    logic [N_REQ-1:0]           req_ready;
    logic                       sram_w_en;
    logic [CH_W-1:0]            sram_ch_addr;
    logic [ADDR_W-1:0]          sram_addr;
    logic [BIT_WIDTH-1:0]       sram_data_in;
    logic [CH_W-1:0]            sram_out_addr;
    logic                       rd_valid;
    logic [CH_W-1:0]            rd_ch;
    logic                       rd_ready = 1'b0;
    logic                       busy;
    logic                       done;
    logic                       err;

    always #5 clk = ~clk;

    output_sram_scheduler #(
        .BIT_WIDTH(BIT_WIDTH), .CHANNELS(CHANNELS), .SIZE(SIZE), .N_REQ(N_REQ)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .req_valid(req_valid), .req_ch(req_ch), .req_data(req_data), .req_ready(req_ready),
        .sram_w_en(sram_w_en), .sram_ch_addr(sram_ch_addr), .sram_addr(sram_addr),
        .sram_data_in(sram_data_in), .sram_out_addr(sram_out_addr),
        .rd_valid(rd_valid), .rd_ch(rd_ch), .rd_ready(rd_ready),
        .busy(busy), .done(done), .err(err)
    );

    // SRAM: one plane per row, synchronous write and synchronous row read, cleared by reset.
    logic [BIT_WIDTH-1:0] mem      [CHANNELS][PLANE];
    logic [BIT_WIDTH-1:0] data_out [PLANE];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++)
                for (int a = 0; a < PLANE; a++) mem[c][a] <= '0;
            for (int a = 0; a < PLANE; a++) data_out[a] <= '0;
        end else begin
            if (sram_w_en) mem[sram_ch_addr][sram_addr] <= sram_data_in;
            for (int a = 0; a < PLANE; a++) data_out[a] <= mem[sram_out_addr][a];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model state: transaction-level view of one layer.
    typedef struct packed {
        logic [CH_W-1:0]      ch;
        logic [ADDR_W-1:0]    addr;
        logic [BIT_WIDTH-1:0] data;
    } wr_t;

    wr_t                  wq[$];
    int                   rq[$];
    int                   m_cnt  [N_REQ];
    int                   m_last [N_REQ];
    int                   m_ptr = 0;
    bit                   m_bm   [CHANNELS];
    bit                   m_active = 0, m_err = 0, m_done_pulse = 0;
    logic [BIT_WIDTH-1:0] exp_mem [CHANNELS][PLANE];
    logic [N_REQ-1:0]     exp_ready;
    wr_t                  w;
    int                   g, wch;
    logic [BIT_WIDTH-1:0] wdata;

    function automatic bit m_all_done();
        for (int c = 0; c < CHANNELS; c++) if (!m_bm[c]) return 0;
        return 1;
    endfunction

    task automatic model_reset();
        wq.delete();
        rq.delete();
        m_ptr = 0; m_active = 0; m_err = 0; m_done_pulse = 0;
        for (int i = 0; i < N_REQ; i++) begin m_cnt[i] = 0; m_last[i] = 0; end
        for (int c = 0; c < CHANNELS; c++) begin
            m_bm[c] = 0;
            for (int a = 0; a < PLANE; a++) exp_mem[c][a] = '0;
        end
    endtask

    initial model_reset();

    always @(negedge clk) begin : monitor
        exp_ready = '0;
        if (m_active && !m_all_done()) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (req_valid[(m_ptr + k) % N_REQ]) begin
                    exp_ready[(m_ptr + k) % N_REQ] = 1'b1;
                    break;
                end
            end
        end

        check("busy", busy, m_active);
        check("req_ready", req_ready, exp_ready);
        check("done", done, m_done_pulse);
        check("err", err, m_err);

        if (wq.size() > 0) begin
            w = wq.pop_front();
            check("w_en", sram_w_en, 1'b1);
            check("w_ch", sram_ch_addr, w.ch);
            check("w_addr", sram_addr, w.addr);
            check("w_data", sram_data_in, w.data);
        end else begin
            check("w_en_idle", sram_w_en, 1'b0);
        end

        if (rd_valid) begin
            if (rq.size() == 0) begin
                check("rd_valid_unexpected", rd_valid, 1'b0);
            end else begin
                check("rd_ch", rd_ch, rq[0]);
                for (int a = 0; a < PLANE; a++) check("rd_data", data_out[a], exp_mem[rq[0]][a]);
            end
        end

        m_done_pulse = 0;
        if (reset) begin
            model_reset();
        end else begin
            if (start && !m_active) begin
                m_active = 1;
                m_err    = 0;
                for (int i = 0; i < N_REQ; i++) m_cnt[i] = 0;
                for (int c = 0; c < CHANNELS; c++) m_bm[c] = 0;
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (exp_ready[i] && req_valid[i]) begin
                    g     = i;
                    wch   = int'(req_ch[g*CH_W +: CH_W]);
                    wdata = req_data[g*BIT_WIDTH +: BIT_WIDTH];
                    if (m_cnt[g] != 0 && wch != m_last[g]) m_err = 1;
                    if (m_bm[wch]) m_err = 1;
                    w.ch   = CH_W'(wch);
                    w.addr = ADDR_W'(m_cnt[g]);
                    w.data = wdata;
                    wq.push_back(w);
                    exp_mem[wch][m_cnt[g]] = wdata;
                    m_last[g] = wch;
                    m_cnt[g]  = m_cnt[g] + 1;
                    if (m_cnt[g] == PLANE) begin
                        m_cnt[g] = 0;
                        m_bm[wch] = 1;
                        if (m_all_done()) for (int c = 0; c < CHANNELS; c++) rq.push_back(c);
                    end
                    m_ptr = (g + 1) % N_REQ;
                end
            end
            if (rd_valid && rd_ready && rq.size() > 0) begin
                void'(rq.pop_front());
                if (rq.size() == 0) begin
                    m_done_pulse = 1;
                    m_active     = 0;
                end
            end
        end
    end

    // Stimulus
    int plan [N_REQ][$];
    bit data_mode = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_plan();
        for (int i = 0; i < N_REQ; i++) plan[i].delete();
    endtask

    task automatic check_zero(input string tag);
        int bad;
        check({tag, "_busy"}, busy, 0);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_w_en"}, sram_w_en, 0);
        check({tag, "_ch_addr"}, sram_ch_addr, 0);
        check({tag, "_addr"}, sram_addr, 0);
        check({tag, "_data_in"}, sram_data_in, 0);
        check({tag, "_out_addr"}, sram_out_addr, 0);
        check({tag, "_rd_valid"}, rd_valid, 0);
        check({tag, "_rd_ch"}, rd_ch, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        bad = 0;
        for (int c = 0; c < CHANNELS; c++)
            for (int a = 0; a < PLANE; a++) if (mem[c][a] !== '0) bad++;
        check({tag, "_sram_clear"}, bad, 0);
    endtask

    task automatic drive_layer(input int p_valid, input int abort_after, input int hold_rd);
        int pos [N_REQ];
        int beat [N_REQ];
        int nbeats, remaining, budget, rd_cycles;
        logic [N_REQ-1:0] xfer;
        for (int i = 0; i < N_REQ; i++) begin pos[i] = 0; beat[i] = 0; end
        nbeats = 0;
        start = 1'b1;
        step();
        start = 1'b0;

        remaining = 0;
        for (int i = 0; i < N_REQ; i++) remaining += plan[i].size() * PLANE;
        budget = 0;
        while (remaining > 0 && budget < 5000) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (pos[i] < plan[i].size()) begin
                    req_ch[i*CH_W +: CH_W] = CH_W'(plan[i][pos[i]]);
                    req_valid[i] = ($urandom_range(99) < p_valid);
                    req_data[i*BIT_WIDTH +: BIT_WIDTH] = data_mode ?
                        BIT_WIDTH'(plan[i][pos[i]] * 16 + beat[i] + 1) : BIT_WIDTH'($urandom);
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
            @(negedge clk);
            xfer = req_valid & req_ready;
            step();
            start = 1'b0;
            for (int i = 0; i < N_REQ; i++) begin
                if (xfer[i]) begin
                    nbeats++;
                    remaining--;
                    beat[i]++;
                    if (beat[i] == PLANE) begin beat[i] = 0; pos[i]++; end
                end
            end
            if (abort_after > 0 && nbeats >= abort_after) begin
                reset = 1'b1;
                req_valid = '0;
                step();
                reset = 1'b0;
                check_zero("abort");
                return;
            end
            if (busy && $urandom_range(15) == 0) start = 1'b1;
            budget++;
        end
        req_valid = '0;
        start = 1'b0;
        check("write_beats_left", remaining, 0);

        rd_cycles = 0;
        budget = 0;
        while (busy && budget < 3000) begin
            rd_ready = (rd_cycles >= hold_rd) && ($urandom_range(1) == 1);
            start = ($urandom_range(7) == 0);
            if (rd_valid) rd_cycles++;
            step();
            budget++;
        end
        rd_ready = 1'b0;
        start = 1'b0;
        step();
        check("layer_finished", busy, 1'b0);
        check("reads_pending", rq.size(), 0);
    endtask

    task automatic random_plan();
        int perm [CHANNELS];
        int j, t;
        clear_plan();
        for (int c = 0; c < CHANNELS; c++) perm[c] = c;
        for (int c = CHANNELS - 1; c > 0; c--) begin
            j = $urandom_range(c);
            t = perm[c]; perm[c] = perm[j]; perm[j] = t;
        end
        for (int c = 0; c < CHANNELS; c++) plan[$urandom_range(N_REQ - 1)].push_back(perm[c]);
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        check_zero("reset");

        // Reset after five beats aborts the layer.
        clear_plan();
        plan[0].push_back(0); plan[0].push_back(1);
        plan[1].push_back(2); plan[1].push_back(3);
        drive_layer(70, 5, 0);
        step();

        // Lane 0 streams ch0 with data 1..9; consumer stalls first.
        data_mode = 1;
        drive_layer(60, 0, 5);
        for (int a = 0; a < PLANE; a++) check("sram_ch0", mem[0][a], a + 1);

        // Both lanes valid every cycle.
        data_mode = 0;
        clear_plan();
        plan[0].push_back(1); plan[0].push_back(3);
        plan[1].push_back(0); plan[1].push_back(2);
        drive_layer(100, 0, 0);

        // Lane 1 re-sends a completed channel.
        clear_plan();
        plan[0].push_back(0); plan[0].push_back(1);
        plan[1].push_back(2); plan[1].push_back(2); plan[1].push_back(3);
        drive_layer(80, 0, 2);
        check("err_sticky", err, 1'b1);

        for (int n = 0; n < 5; n++) begin
            random_plan();
            drive_layer($urandom_range(30, 100), 0, $urandom_range(3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
